// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and edge-mode constants for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } t_db_state;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  // Any mode other than the two single-edge modes behaves as "both edges".
  function automatic logic edge_pulses(input logic rising, input int mode);
    return rising ? (mode != EDGE_FALLING) : (mode != EDGE_RISING);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - reset-to-0 flop chain for bringing an asynchronous input into the clock domain
module sync_chain #(
  parameter int G_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [G_STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[G_STAGES-2:0], d};
    end
  end

  assign q = chain[G_STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - synchronise, debounce and edge-detect a raw button into a one-cycle pulse
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int G_SYNC_STAGES     = 2,
  parameter int G_DEBOUNCE_CYCLES = 16,
  parameter int G_EDGE_MODE       = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic button_in,
  output logic level_out,
  output logic pulse_out,
  output logic bouncing
);

  localparam int CW = $clog2(G_DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(G_DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (G_EDGE_MODE < EDGE_RISING || G_EDGE_MODE > EDGE_BOTH) begin : g_bad_edge_mode
    $warning("debounce_pulse: G_EDGE_MODE %0d is not 0..2, treated as both edges", G_EDGE_MODE);
  end

  logic          sync_q;
  t_db_state     state;
  logic [CW-1:0] count;

  sync_chain #(.G_STAGES(G_SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (button_in),
    .q       (sync_q)
  );

  // count holds how many consecutive cycles sync_q has disagreed with level_out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= STABLE_LOW;
      count     <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
      bouncing  <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      if (!enable) begin
        state    <= level_out ? STABLE_HIGH : STABLE_LOW;
        count    <= '0;
        bouncing <= 1'b0;
      end else begin
        case (state)
          STABLE_LOW: begin
            if (sync_q) begin
              state    <= CHECK_HIGH;
              count    <= CNT_ONE;
              bouncing <= 1'b1;
            end
          end
          CHECK_HIGH: begin
            if (!sync_q) begin
              state    <= STABLE_LOW;
              count    <= '0;
              bouncing <= 1'b0;
            end else if (count == CNT_MAX) begin
              state     <= STABLE_HIGH;
              count     <= '0;
              bouncing  <= 1'b0;
              level_out <= 1'b1;
              pulse_out <= edge_pulses(1'b1, G_EDGE_MODE);
            end else if (count < CNT_MAX) begin
              count <= count + CNT_ONE;
            end
          end
          STABLE_HIGH: begin
            if (!sync_q) begin
              state    <= CHECK_LOW;
              count    <= CNT_ONE;
              bouncing <= 1'b1;
            end
          end
          CHECK_LOW: begin
            if (sync_q) begin
              state    <= STABLE_HIGH;
              count    <= '0;
              bouncing <= 1'b0;
            end else if (count == CNT_MAX) begin
              state     <= STABLE_LOW;
              count     <= '0;
              bouncing  <= 1'b0;
              level_out <= 1'b0;
              pulse_out <= edge_pulses(1'b0, G_EDGE_MODE);
            end else if (count < CNT_MAX) begin
              count <= count + CNT_ONE;
            end
          end
          default: begin
            state    <= STABLE_LOW;
            count    <= '0;
            bouncing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// tb/tb_debounce_pulse.sv - four debouncer configurations checked against a run-length model
module tb_debounce_pulse;

  localparam int ND = 4;

  logic clock;
  logic reset_n;
  logic enable;
  logic button_in;
  wire [ND-1:0] lvl;
  wire [ND-1:0] pls;
  wire [ND-1:0] bnc;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  // Configurations: sync stages, debounce cycles, edge mode.
  function automatic int s_of(input int d);
    return (d == 3) ? 3 : 2;
  endfunction
  function automatic int n_of(input int d);
    return (d == 3) ? 1 : 4;
  endfunction
  function automatic int m_of(input int d);
    return (d == 3) ? 2 : d;
  endfunction

  debounce_pulse #(.G_SYNC_STAGES(2), .G_DEBOUNCE_CYCLES(4), .G_EDGE_MODE(0)) u_rise (
    .clock(clock), .reset_n(reset_n), .enable(enable), .button_in(button_in),
    .level_out(lvl[0]), .pulse_out(pls[0]), .bouncing(bnc[0]));
  debounce_pulse #(.G_SYNC_STAGES(2), .G_DEBOUNCE_CYCLES(4), .G_EDGE_MODE(1)) u_fall (
    .clock(clock), .reset_n(reset_n), .enable(enable), .button_in(button_in),
    .level_out(lvl[1]), .pulse_out(pls[1]), .bouncing(bnc[1]));
  debounce_pulse #(.G_SYNC_STAGES(2), .G_DEBOUNCE_CYCLES(4), .G_EDGE_MODE(2)) u_both (
    .clock(clock), .reset_n(reset_n), .enable(enable), .button_in(button_in),
    .level_out(lvl[2]), .pulse_out(pls[2]), .bouncing(bnc[2]));
  debounce_pulse #(.G_SYNC_STAGES(3), .G_DEBOUNCE_CYCLES(1), .G_EDGE_MODE(2)) u_fast (
    .clock(clock), .reset_n(reset_n), .enable(enable), .button_in(button_in),
    .level_out(lvl[3]), .pulse_out(pls[3]), .bouncing(bnc[3]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: a commit happens once the synchronised input has disagreed with the
  // debounced level for N+1 consecutive enabled cycles.
  bit hist [ND][4];
  int run  [ND];
  bit m_lvl[ND];
  bit m_pls[ND];
  bit m_bnc[ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) hist[d][k] = 1'b0;
      run[d] = 0; m_lvl[d] = 0; m_pls[d] = 0; m_bnc[d] = 0;
    end
    forever begin
      @(posedge clock or negedge reset_n);
      for (int d = 0; d < ND; d++) begin
        if (!reset_n) begin
          for (int k = 0; k < 4; k++) hist[d][k] = 1'b0;
          run[d] = 0; m_lvl[d] = 0; m_pls[d] = 0; m_bnc[d] = 0;
        end else begin
          bit sq;
          sq = hist[d][s_of(d)-1];
          for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
          hist[d][0] = button_in;
          m_pls[d] = 0;
          if (!enable || sq == m_lvl[d]) begin
            run[d] = 0;
          end else begin
            run[d]++;
            if (run[d] == n_of(d) + 1) begin
              m_lvl[d] = sq;
              m_pls[d] = sq ? (m_of(d) != 1) : (m_of(d) != 0);
              run[d] = 0;
            end
          end
          m_bnc[d] = (run[d] > 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_on) begin
        for (int d = 0; d < ND; d++) begin
          checks += 3;
          if (lvl[d] !== m_lvl[d]) begin
            errors++;
            $display("FAIL model_level dut%0d t=%0t got %b want %b", d, $time, lvl[d], m_lvl[d]);
          end
          if (pls[d] !== m_pls[d]) begin
            errors++;
            $display("FAIL model_pulse dut%0d t=%0t got %b want %b", d, $time, pls[d], m_pls[d]);
          end
          if (bnc[d] !== m_bnc[d]) begin
            errors++;
            $display("FAIL model_bouncing dut%0d t=%0t got %b want %b", d, $time, bnc[d], m_bnc[d]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Per-run observations, edges numbered from 1 for the first edge of the run.
  int first_pulse[ND];
  int npulse[ND];
  int first_bnc[ND];
  int last_bnc[ND];
  bit pat_q[$];

  task automatic run_edges(input int n);
    for (int d = 0; d < ND; d++) begin
      first_pulse[d] = 0; npulse[d] = 0; first_bnc[d] = 0; last_bnc[d] = 0;
    end
    for (int e = 1; e <= n; e++) begin
      if (pat_q.size() > 0) button_in = pat_q.pop_front();
      @(posedge clock);
      #1;
      for (int d = 0; d < ND; d++) begin
        if (pls[d] === 1'b1) begin
          npulse[d]++;
          if (first_pulse[d] == 0) first_pulse[d] = e;
        end
        if (bnc[d] === 1'b1) begin
          if (first_bnc[d] == 0) first_bnc[d] = e;
          last_bnc[d] = e;
        end
      end
    end
  endtask

  int tot;
  int exp_count[5];

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    button_in = 1'b0;
    #1;
    chk("reset_level", int'(lvl[0]), 0);
    chk("reset_pulse", int'(pls[0]), 0);
    chk("reset_bouncing", int'(bnc[0]), 0);
    #22 reset_n = 1'b1;
    cmp_on = 1;
    @(posedge clock);
    #1;
    run_edges(6);

    // Clean rising step
    button_in = 1'b1;
    run_edges(20);
    chk("step_pulse_edge", first_pulse[0], 7);
    chk("step_pulse_count", npulse[0], 1);
    chk("step_bounce_first", first_bnc[0], 3);
    chk("step_bounce_last", last_bnc[0], 6);
    chk("step_level", int'(lvl[0]), 1);
    chk("step_falling_mode_quiet", npulse[1], 0);
    chk("step_both_mode", npulse[2], 1);
    chk("step_fast_pulse_edge", first_pulse[3], 5);

    // Clean falling step
    button_in = 1'b0;
    run_edges(20);
    chk("fall_rising_mode_quiet", npulse[0], 0);
    chk("fall_falling_mode", npulse[1], 1);
    chk("fall_both_mode", npulse[2], 1);
    chk("fall_level", int'(lvl[0]), 0);

    // Bounce then settle high
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_edges(20);
    chk("bounce_pulse_edge", first_pulse[0], 11);
    chk("bounce_pulse_count", npulse[0], 1);
    button_in = 1'b0;
    run_edges(20);

    // Enable dropped mid-qualification
    button_in = 1'b1;
    run_edges(4);
    enable = 1'b0;
    run_edges(5);
    chk("disabled_pulse_count", npulse[0], 0);
    chk("disabled_bouncing", first_bnc[0], 0);
    chk("disabled_level", int'(lvl[0]), 0);
    enable = 1'b1;
    run_edges(8);
    chk("reenable_pulse_edge", first_pulse[0], 5);
    chk("reenable_level", int'(lvl[0]), 1);
    button_in = 1'b0;
    run_edges(20);

    // Asynchronous reset mid-qualification with the input held high
    button_in = 1'b1;
    run_edges(4);
    chk("prereset_bouncing", int'(bnc[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_bouncing", int'(bnc[0]), 0);
    chk("async_reset_level", int'(lvl[0]), 0);
    chk("async_reset_pulse", int'(pls[0]), 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    run_edges(10);
    chk("postreset_pulse_edge", first_pulse[0], 7);
    chk("postreset_level", int'(lvl[0]), 1);
    button_in = 1'b0;
    run_edges(20);

    // Downstream modulo-4 counter driven by the rising-edge pulse
    exp_count = '{1, 2, 3, 0, 1};
    tot = 0;
    for (int p = 0; p < 5; p++) begin
      button_in = 1'b1;
      run_edges(12);
      tot += npulse[0];
      button_in = 1'b0;
      run_edges(12);
      tot += npulse[0];
      chk("press_counter", tot % 4, exp_count[p]);
    end

    // Random holds, enable drops and asynchronous resets
    repeat (400) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b1;
      end
      enable = ($urandom_range(0, 9) != 0);
      button_in = ~button_in;
      if ($urandom_range(0, 1) == 0) run_edges($urandom_range(1, 4));
      else run_edges($urandom_range(5, 14));
    end

    @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
